// File: rtl/mem_stage.sv
// Memory stage of the 5-stage MIPS pipeline: latches the execute bus, aligns load
// data from the data SRAM, and drives the writeback bus and memory-stage forwarding.
module mem_stage #(
   parameter int ES_TO_MS_BUS_WD = 128,
   parameter int MS_TO_WS_BUS_WD = 123,
   parameter int MS_FWD_BUS_WD   = 39
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       ws_allowin,
   output logic                       ms_allowin,
   input  logic                       es_to_ms_valid,
   input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
   input  logic [31:0]                data_sram_rdata,
   output logic                       ms_to_ws_valid,
   output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
   output logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus,
   output logic                       ms_ex,
   input  logic                       flush
);

   function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
      logic signed [7:0] sb;
      sb = b;
      return sgn ? 32'(sb) : 32'(b);
   endfunction

   function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
      logic signed [15:0] sh;
      sh = h;
      return sgn ? 32'(sh) : 32'(h);
   endfunction

   logic                       ms_valid;
   logic                       ms_ready_go;
   logic [ES_TO_MS_BUS_WD-1:0] ms_bus_p0;
   logic                       rdata_hold;
   logic [31:0]                rdata_r;

   logic [31:0] badvaddr;
   logic [10:0] c0_bus;
   logic        bd;
   logic        ex;
   logic [4:0]  excode;
   logic        ld_lw, ld_lb, ld_lbu, ld_lh, ld_lhu, ld_lwl, ld_lwr;
   logic        res_from_mem;
   logic        gr_we;
   logic [4:0]  dest;
   logic [31:0] alu_res;
   logic [31:0] pc;

   assign {badvaddr, c0_bus, bd, ex, excode,
           ld_lw, ld_lb, ld_lbu, ld_lh, ld_lhu, ld_lwl, ld_lwr,
           res_from_mem, gr_we, dest, alu_res, pc} = ms_bus_p0;

   // Handshake
   assign ms_ready_go    = 1'b1;
   assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
   assign ms_to_ws_valid = ms_valid && ms_ready_go && !flush;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ms_valid <= 1'b0;
      end else if (ms_allowin) begin
         ms_valid <= es_to_ms_valid && !flush;
      end else if (flush) begin
         ms_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ms_bus_p0 <= '0;
      end else if (es_to_ms_valid && ms_allowin) begin
         ms_bus_p0 <= es_to_ms_bus;
      end
   end

   // SRAM data is only guaranteed in the first cycle; keep a copy across stalls
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rdata_hold <= 1'b0;
         rdata_r    <= '0;
      end else if (ms_allowin || flush) begin
         rdata_hold <= 1'b0;
      end else if (ms_valid && !rdata_hold) begin
         rdata_hold <= 1'b1;
         rdata_r    <= data_sram_rdata;
      end
   end

   logic [31:0] mem_word;
   logic [1:0]  pos;
   logic [31:0] byte_shift;
   logic [15:0] half_sel;
   logic [31:0] load_result;
   logic [3:0]  load_wen;
   logic [31:0] final_result;
   logic [3:0]  rf_wen;

   assign mem_word   = rdata_hold ? rdata_r : data_sram_rdata;
   assign pos        = alu_res[1:0];
   assign byte_shift = mem_word >> {pos, 3'b000};
   assign half_sel   = pos[1] ? mem_word[31:16] : mem_word[15:0];

   always_comb begin
      load_result = mem_word;
      load_wen    = {4{gr_we}};
      if (ld_lb || ld_lbu) begin
         load_result = ext_byte(byte_shift[7:0], ld_lb);
      end else if (ld_lh || ld_lhu) begin
         load_result = ext_half(half_sel, ld_lh);
      end else if (ld_lwl) begin
         load_result = mem_word << {2'd3 - pos, 3'b000};
         case (pos)
            2'd0:    load_wen = 4'b1000;
            2'd1:    load_wen = 4'b1100;
            2'd2:    load_wen = 4'b1110;
            default: load_wen = 4'b1111;
         endcase
      end else if (ld_lwr) begin
         load_result = mem_word >> {pos, 3'b000};
         case (pos)
            2'd0:    load_wen = 4'b1111;
            2'd1:    load_wen = 4'b0111;
            2'd2:    load_wen = 4'b0011;
            default: load_wen = 4'b0001;
         endcase
      end else if (ld_lw) begin
         load_result = mem_word;
      end
   end

   assign final_result = res_from_mem ? load_result : alu_res;
   assign ms_ex        = ms_valid && ex;
   // An excepting instruction must never update the register file
   assign rf_wen       = ex ? 4'b0000 : load_wen;

   assign ms_to_ws_bus = {badvaddr, c0_bus, bd, ex, excode,
                          rf_wen, dest, final_result, pc};

   assign ms_fwd_bus = {ms_valid && c0_bus[8],
                        ms_valid && (rf_wen != 4'b0000) && !flush,
                        dest, final_result};

endmodule
